imem_boot_loader: RTL and testbench

//   Boot sequencer for pipelinedProcessor. Streams a program image from a valid/ready

---
 rtl/boot_pkg.sv | 19 +
 rtl/boot_cycle_timer.sv | 27 ++
 rtl/imem_boot_loader.sv | 162 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared boot-loader definitions: sequencer state encoding and the widths
// that the processor top also relies on.
package boot_pkg;

  localparam int BOOT_ADDR_W = 32;
  localparam int BOOT_DATA_W = 16;
  localparam int BOOT_CNT_W  = 16;
  localparam int BOOT_TMR_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4,
    ERROR = 3'd5
  } boot_state_t;

endpackage

// File: rtl/boot_cycle_timer.sv
// Loadable down-counter that sits at zero until it is reloaded. Shared by the
// memory-clear phase and the CPU reset-hold phase.
module boot_cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: clears instruction memory, streams an image into it over the fm
// write port, then releases the CPU. Define BOOT_CHECKSUM_EN to verify the image sum.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int                ADDR_W     = BOOT_ADDR_W,
  parameter int                DATA_W     = BOOT_DATA_W,
  parameter logic [ADDR_W-1:0] START_ADDR = 'h20,
  parameter int                MAX_WORDS  = 1024,
  parameter int                CLR_CYCLES = 2,
  parameter int                RST_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  input  logic [DATA_W-1:0]     exp_sum,
  output logic                  rst_fm,
  output logic                  write_enable_fm,
  output logic [ADDR_W-1:0]     write_addr_fm,
  output logic [DATA_W-1:0]     write_data_fm,
  output logic                  cpu_reset,
  input  logic                  irq_in,
  output logic                  interrupt,
  output logic                  done,
  output logic                  error,
  output logic [BOOT_CNT_W-1:0] word_count,
  output boot_state_t           state_dbg
);

  boot_state_t           state, next_state;
  logic [ADDR_W-1:0]     addr_q;
  logic                  accept;
  logic                  sum_ok;
  logic                  enter_clear;
  logic                  tmr_load;
  logic                  tmr_zero;
  logic [BOOT_TMR_W-1:0] tmr_val;

  // Source handshake: a word transfers on any rising edge where in_valid and
  // in_ready are both high; in_data/in_last are ignored in every other cycle.
  assign accept    = in_valid && in_ready;
  assign state_dbg = state;

`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (enter_clear) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + in_data;
    end
  end

  // The final word is folded in combinationally so the verdict lands on its accept edge.
  assign sum_ok = ((sum_q + in_data) == exp_sum);
`else
  logic [DATA_W-1:0] exp_sum_unused;
  assign exp_sum_unused = exp_sum;
  assign sum_ok         = 1'b1;
`endif

  boot_cycle_timer #(
    .W(BOOT_TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    unique case (state)
      IDLE:  if (start) next_state = CLEAR;
      CLEAR: if (tmr_zero) next_state = LOAD;
      LOAD: begin
        if (start) begin
          next_state = CLEAR;
        end else if (accept) begin
          if (in_last) begin
            next_state = sum_ok ? HOLD : ERROR;
          end else if (word_count == BOOT_CNT_W'(MAX_WORDS - 1)) begin
            next_state = ERROR;
          end
        end
      end
      HOLD: begin
        if (start) begin
          next_state = CLEAR;
        end else if (tmr_zero) begin
          next_state = RUN;
        end
      end
      RUN, ERROR: if (start) next_state = CLEAR;
      default: next_state = IDLE;
    endcase
    enter_clear = (next_state == CLEAR) && (state != CLEAR);
    // HOLD spans the last-write cycle plus RST_CYCLES more, so the timer loads RST_CYCLES.
    if (enter_clear) begin
      tmr_load = 1'b1;
      tmr_val  = BOOT_TMR_W'(CLR_CYCLES - 1);
    end else if ((next_state == HOLD) && (state != HOLD)) begin
      tmr_load = 1'b1;
      tmr_val  = BOOT_TMR_W'(RST_CYCLES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_fm          <= 1'b0;
      in_ready        <= 1'b0;
      cpu_reset       <= 1'b1;
      done            <= 1'b0;
      error           <= 1'b0;
      interrupt       <= 1'b0;
      write_enable_fm <= 1'b0;
      write_addr_fm   <= START_ADDR;
      write_data_fm   <= '0;
      addr_q          <= START_ADDR;
      word_count      <= '0;
    end else begin
      rst_fm          <= (next_state == CLEAR);
      in_ready        <= (next_state == LOAD);
      cpu_reset       <= (next_state != RUN);
      done            <= (next_state == RUN);
      error           <= (next_state == ERROR);
      interrupt       <= irq_in && (state == RUN) && (next_state == RUN);
      // An accepted word is always written, even if a restart arrives alongside it.
      write_enable_fm <= accept;
      if (accept) begin
        write_addr_fm <= addr_q;
        write_data_fm <= in_data;
      end
      if (enter_clear) begin
        addr_q     <= START_ADDR;
        word_count <= '0;
      end else if (accept) begin
        addr_q     <= addr_q + ADDR_W'(1);
        word_count <= word_count + BOOT_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed and randomized image loads
// scored against a transaction-level model of the expected memory writes.
`timescale 1ns/1ps
module tb_imem_boot_loader;
  import boot_pkg::*;

  localparam int          MAX_W = 12;
  localparam int          CLR_C = 2;
  localparam int          RST_C = 4;
  localparam logic [31:0] START = 32'h20;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        irq_in = 1'b0;
  logic [15:0] in_data = '0;
  logic [15:0] exp_sum = '0;
  logic        in_ready, rst_fm, write_enable_fm, cpu_reset, interrupt, done, error;
  logic [31:0] write_addr_fm;
  logic [15:0] write_data_fm;
  logic [15:0] word_count;
  boot_state_t state_dbg;

  logic [15:0] img[0:31];
  logic [47:0] exp_q[$];
  logic [47:0] mon_e;
  int          n_vec = 0;
  int          n_err = 0;

  imem_boot_loader #(
    .MAX_WORDS (MAX_W),
    .CLR_CYCLES(CLR_C),
    .RST_CYCLES(RST_C)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_last         (in_last),
    .exp_sum         (exp_sum),
    .rst_fm          (rst_fm),
    .write_enable_fm (write_enable_fm),
    .write_addr_fm   (write_addr_fm),
    .write_data_fm   (write_data_fm),
    .cpu_reset       (cpu_reset),
    .irq_in          (irq_in),
    .interrupt       (interrupt),
    .done            (done),
    .error           (error),
    .word_count      (word_count),
    .state_dbg       (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sum_img(input int n);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = s + img[i];
    return s;
  endfunction

  // Scoreboard: every observed memory write must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && write_enable_fm === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("write", {16'h0, write_addr_fm, write_data_fm}, {16'h0, mon_e});
      end
    end
  end

  // Pulse start, then verify the restart state and the memory-clear pulse length.
  task automatic begin_load();
    int hi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cpu_reset_restart", cpu_reset, 1);
    check("done_cleared", done, 0);
    check("error_cleared", error, 0);
    check("count_cleared", word_count, 0);
    hi = 0;
    while (rst_fm === 1'b1 && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    check("rst_fm_len", hi, CLR_C);
    check("in_ready_load", in_ready, 1);
  endtask

  // Offer words 0..target-1 of img; mode 0 = always valid, 1 = every other cycle, 2 = random.
  task automatic drive_words(input int target, input int mode, input int n);
    int acc, guard;
    bit phase, v;
    acc = 0;
    guard = 0;
    phase = 1'b1;
    while (acc < target && guard < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = phase;
        default: v = 1'($urandom_range(0, 1));
      endcase
      phase    = ~phase;
      in_valid = v;
      in_data  = img[acc];
      in_last  = (acc == n - 1);
      if (v && in_ready === 1'b1) begin
        exp_q.push_back({START + 32'(acc), img[acc]});
        acc++;
      end
      @(negedge clk);
      guard++;
    end
    check("accepted_words", acc, target);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Finish a load already past CLEAR and check the outcome the model predicts.
  task automatic finish_load(input int n, input int mode, input logic [15:0] exp_s);
    int  exp_acc, gap;
    bit  err;
    exp_acc = (n > MAX_W) ? MAX_W : n;
    err     = (n > MAX_W) || (CHK && (sum_img(n) != exp_s));
    drive_words(exp_acc, mode, n);
    check("irq_gated_load", interrupt, 0);
    irq_in = 1'b0;
    if (err) begin
      in_valid = (n > exp_acc);
      in_data  = img[exp_acc];
      repeat (4) begin
        check("in_ready_closed", in_ready, 0);
        @(negedge clk);
      end
      in_valid = 1'b0;
      check("error_set", error, 1);
      check("cpu_held", cpu_reset, 1);
      check("done_low", done, 0);
      check("count_err", word_count, exp_acc);
      check("state_err", state_dbg, ERROR);
    end else begin
      gap = 0;
      while (cpu_reset === 1'b1 && gap < 50) begin
        @(negedge clk);
        gap++;
      end
      check("cpu_release", gap, RST_C + 1);
      check("done_set", done, 1);
      check("error_low", error, 0);
      check("count_ok", word_count, exp_acc);
      check("state_run", state_dbg, RUN);
      irq_in = 1'b1;
      check("irq_same_cycle", interrupt, 0);
      @(negedge clk);
      check("irq_run", interrupt, 1);
      irq_in = 1'b0;
      @(negedge clk);
      check("irq_clear", interrupt, 0);
    end
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  task automatic run_load(input int n, input int mode, input logic [15:0] exp_s);
    exp_sum = exp_s;
    irq_in  = 1'b1;
    begin_load();
    finish_load(n, mode, exp_s);
  endtask

  initial begin
    logic [15:0] prog[0:8];
    int          n, mode;
    logic [15:0] es;
    prog = '{16'h7100, 16'h0023, 16'h2200, 16'h6140, 16'h52A0,
             16'h2500, 16'h4500, 16'h4F00, 16'h2700};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_rst_fm", rst_fm, 0);
    check("rst_we", write_enable_fm, 0);
    check("rst_addr", write_addr_fm, START);
    check("rst_data", write_data_fm, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_interrupt", interrupt, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_count", word_count, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_state", state_dbg, IDLE);
    check("idle_in_ready", in_ready, 0);

    // Reference program, back-to-back and then with gaps
    for (int i = 0; i < 9; i++) img[i] = prog[i];
    run_load(9, 0, sum_img(9));
    run_load(9, 1, sum_img(9));

    // Image one word larger than the limit
    for (int i = 0; i < 32; i++) img[i] = 16'($urandom);
    run_load(MAX_W + 1, 0, 16'h0);

    // Restart in the middle of a load
    for (int i = 0; i < 9; i++) img[i] = prog[i];
    exp_sum = sum_img(9);
    begin_load();
    drive_words(3, 2, 9);
    run_load(9, 0, sum_img(9));

    // Async reset in the middle of a load, then a fresh load
    begin_load();
    drive_words(4, 0, 9);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset_we", write_enable_fm, 0);
    check("areset_addr", write_addr_fm, START);
    check("areset_count", word_count, 0);
    check("areset_cpu", cpu_reset, 1);
    check("areset_ready", in_ready, 0);
    check("areset_state", state_dbg, IDLE);
    check("areset_drained", exp_q.size(), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_load(9, 2, sum_img(9));

    // Checksum pair: matching and non-matching expected sum
    img[0] = 16'h0001;
    img[1] = 16'h0002;
    run_load(2, 0, 16'h0003);
    run_load(2, 0, 16'h0004);

    // Randomized images, lengths, pacing and checksum agreement
    for (int r = 0; r < 10; r++) begin
      n    = $urandom_range(1, MAX_W + 3);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 32; i++) img[i] = 16'($urandom);
      es   = ($urandom_range(0, 3) == 0) ? sum_img(n) + 16'd1 : sum_img(n);
      run_load(n, mode, es);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
